// File: rtl/ppu_pkg.sv
// Shared PPU definitions: mode encoding, framebuffer-writer states and frame geometry.
// Also holds the helper that left-aligns a partially filled pixel group.
package ppu_pkg;

   typedef enum logic [1:0] {
      H_BLANK = 2'd0,
      V_BLANK = 2'd1,
      SCAN    = 2'd2,
      DRAW    = 2'd3
   } PPU_STATES_t;

   typedef enum logic [1:0] {
      FBW_WAIT_FRAME = 2'd0,
      FBW_LINE       = 2'd1,
      FBW_FLUSH      = 2'd2,
      FBW_FRAME_END  = 2'd3
   } FBW_STATES_t;

   localparam int H_PIX             = 160;
   localparam int V_LINES           = 144;
   localparam int FB_BYTES_PER_LINE = 40;
   localparam int FB_BUF_BYTES      = 5760;

   // Moves the pixels collected so far to the top of the byte; empty slots read as 00.
   function automatic logic [7:0] flush_align(input logic [7:0] shift, input logic [1:0] slot);
      logic [7:0] aligned;
      case (slot)
         2'd1:    aligned = {shift[1:0], 6'b0};
         2'd2:    aligned = {shift[3:0], 4'b0};
         2'd3:    aligned = {shift[5:0], 2'b0};
         default: aligned = shift;
      endcase
      return aligned;
   endfunction

endpackage

// File: rtl/ppu_px_packer.sv
// Maps each accepted pixel through the palette and packs four 2-bit shades per byte.
// A flush emits a partially filled group left-aligned; the byte strobe is registered.
module ppu_px_packer #(
   parameter bit APPLY_PALETTE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] px_in,
   input  logic       accept,
   input  logic       flush,
   input  logic [7:0] palette,
   output logic [1:0] slot,
   output logic [7:0] pack_data,
   output logic       pack_valid
);
   import ppu_pkg::*;

   logic [1:0] shade;
   logic [7:0] shift_reg;
   logic [1:0] slot_reg;
   logic [7:0] data_reg;
   logic       valid_reg;

   always_comb begin
      shade = px_in;
      if (APPLY_PALETTE) begin
         shade = palette[{px_in, 1'b1} -: 2];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= 8'h00;
         slot_reg  <= 2'd0;
         data_reg  <= 8'h00;
         valid_reg <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         if (accept) begin
            if (slot_reg == 2'd3) begin
               data_reg  <= {shift_reg[5:0], shade};
               valid_reg <= 1'b1;
               shift_reg <= 8'h00;
               slot_reg  <= 2'd0;
            end else begin
               shift_reg <= {shift_reg[5:0], shade};
               slot_reg  <= slot_reg + 2'd1;
            end
         end else if (flush) begin
            if (slot_reg != 2'd0) begin
               data_reg  <= flush_align(shift_reg, slot_reg);
               valid_reg <= 1'b1;
            end
            shift_reg <= 8'h00;
            slot_reg  <= 2'd0;
         end
      end
   end

   assign slot       = slot_reg;
   assign pack_data  = data_reg;
   assign pack_valid = valid_reg;

endmodule

// File: rtl/ppu_fb_writer.sv
// Captures PPU pixels into the back half of a double-buffered 2bpp framebuffer,
// tracks line/frame position from PPU mode edges and swaps buffers at frame end.
module ppu_fb_writer #(
   parameter int H_PIX         = ppu_pkg::H_PIX,
   parameter int V_LINES       = ppu_pkg::V_LINES,
   parameter int FB_AW         = 14,
   parameter bit APPLY_PALETTE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       px_in,
   input  logic             px_valid,
   input  logic [1:0]       ppu_mode,
   input  logic [7:0]       palette,
   input  logic             disp_busy,
   output logic             fb_we,
   output logic [FB_AW-1:0] fb_addr,
   output logic [7:0]       fb_wdata,
   output logic             front_buf,
   output logic             frame_done,
   output logic             frame_dropped,
   output logic             line_overrun
);
   import ppu_pkg::*;

   localparam int XW        = $clog2(H_PIX + 1);
   localparam int YW        = $clog2(V_LINES);
   localparam int BUF_BYTES = FB_BYTES_PER_LINE * V_LINES;
   localparam logic [XW-1:0] X_LIM  = XW'(H_PIX);
   localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

   FBW_STATES_t state_reg, state_next;
   PPU_STATES_t mode_in, mode_reg;
   logic [XW-1:0]    x_reg, x_next;
   logic [YW-1:0]    y_reg, y_next;
   logic             front_reg, front_next;
   logic             dropped_reg, dropped_next;
   logic             overrun_reg, overrun_next;
   logic             forced_reg, forced_next;
   logic             accept_px, flush_px;
   logic [1:0]       slot;
   logic             write_event;
   logic [FB_AW-1:0] y_ext, base_addr, addr_calc, addr_reg;

   assign mode_in = PPU_STATES_t'(ppu_mode);

   ppu_px_packer #(
      .APPLY_PALETTE(APPLY_PALETTE)
   ) u_packer (
      .clk       (clk),
      .rst       (rst),
      .px_in     (px_in),
      .accept    (accept_px),
      .flush     (flush_px),
      .palette   (palette),
      .slot      (slot),
      .pack_data (fb_wdata),
      .pack_valid(fb_we)
   );

   always_comb begin
      state_next   = state_reg;
      x_next       = x_reg;
      y_next       = y_reg;
      front_next   = front_reg;
      dropped_next = dropped_reg;
      overrun_next = overrun_reg;
      forced_next  = forced_reg;
      accept_px    = 1'b0;
      flush_px     = 1'b0;
      case (state_reg)
         FBW_WAIT_FRAME: begin
            if (mode_reg == V_BLANK && mode_in == SCAN) begin
               state_next  = FBW_LINE;
               x_next      = '0;
               y_next      = '0;
               forced_next = 1'b0;
            end
         end
         FBW_LINE: begin
            // A pixel landing on the closing mode edge is still taken before the flush.
            if (px_valid) begin
               if (x_reg < X_LIM) begin
                  accept_px = 1'b1;
                  x_next    = x_reg + 1'b1;
               end else begin
                  overrun_next = 1'b1;
               end
            end
            if (mode_reg == DRAW && mode_in == H_BLANK) begin
               state_next = FBW_FLUSH;
            end else if (mode_reg != V_BLANK && mode_in == V_BLANK) begin
               state_next  = FBW_FLUSH;
               forced_next = 1'b1;
            end
         end
         FBW_FLUSH: begin
            flush_px = 1'b1;
            x_next   = '0;
            if (forced_reg || y_reg == Y_LAST) begin
               y_next     = '0;
               state_next = FBW_FRAME_END;
            end else begin
               y_next     = y_reg + 1'b1;
               state_next = FBW_LINE;
            end
         end
         FBW_FRAME_END: begin
            if (!disp_busy) begin
               front_next = ~front_reg;
            end else begin
               dropped_next = 1'b1;
            end
            state_next = FBW_WAIT_FRAME;
         end
         default: state_next = FBW_WAIT_FRAME;
      endcase
   end

   // Byte address of the current group: back*BUF_BYTES + y*40 + x/4, y*40 built from shifts.
   always_comb begin
      y_ext     = FB_AW'(y_reg);
      base_addr = front_reg ? '0 : FB_AW'(BUF_BYTES);
      addr_calc = base_addr + (y_ext << 5) + (y_ext << 3) + FB_AW'(x_reg >> 2);
   end

   assign write_event = (accept_px && slot == 2'd3) || (flush_px && slot != 2'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= FBW_WAIT_FRAME;
         mode_reg    <= H_BLANK;
         x_reg       <= '0;
         y_reg       <= '0;
         front_reg   <= 1'b1;
         dropped_reg <= 1'b0;
         overrun_reg <= 1'b0;
         forced_reg  <= 1'b0;
         addr_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         mode_reg    <= mode_in;
         x_reg       <= x_next;
         y_reg       <= y_next;
         front_reg   <= front_next;
         dropped_reg <= dropped_next;
         overrun_reg <= overrun_next;
         forced_reg  <= forced_next;
         if (write_event) begin
            addr_reg <= addr_calc;
         end
      end
   end

   assign fb_addr       = addr_reg;
   assign front_buf     = front_reg;
   assign frame_done    = (state_reg == FBW_FRAME_END);
   assign frame_dropped = dropped_reg;
   assign line_overrun  = overrun_reg;

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Directed bench for ppu_fb_writer: line packing, palette, flush, buffer swap, overrun, reset.
module tb_ppu_fb_writer;
   localparam int FB_AW = 14;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       px_in = 2'd0;
   logic             px_valid = 1'b0;
   logic [1:0]       ppu_mode = 2'd0;
   logic [7:0]       palette = 8'hE4;
   logic             disp_busy = 1'b0;
   logic             fb_we, front_buf, frame_done, frame_dropped, line_overrun;
   logic [FB_AW-1:0] fb_addr;
   logic [7:0]       fb_wdata;
   logic             raw_we, raw_front, raw_done, raw_dropped, raw_overrun;
   logic [FB_AW-1:0] raw_addr;
   logic [7:0]       raw_wdata;

   ppu_fb_writer #(.H_PIX(160), .V_LINES(144), .FB_AW(FB_AW), .APPLY_PALETTE(1'b1)) u_dut (
      .clk(clk), .rst(rst), .px_in(px_in), .px_valid(px_valid), .ppu_mode(ppu_mode),
      .palette(palette), .disp_busy(disp_busy), .fb_we(fb_we), .fb_addr(fb_addr),
      .fb_wdata(fb_wdata), .front_buf(front_buf), .frame_done(frame_done),
      .frame_dropped(frame_dropped), .line_overrun(line_overrun)
   );

   ppu_fb_writer #(.H_PIX(160), .V_LINES(144), .FB_AW(FB_AW), .APPLY_PALETTE(1'b0)) u_raw (
      .clk(clk), .rst(rst), .px_in(px_in), .px_valid(px_valid), .ppu_mode(ppu_mode),
      .palette(palette), .disp_busy(disp_busy), .fb_we(raw_we), .fb_addr(raw_addr),
      .fb_wdata(raw_wdata), .front_buf(raw_front), .frame_done(raw_done),
      .frame_dropped(raw_dropped), .line_overrun(raw_overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int wq_addr[$];
   int wq_data[$];
   int wq_cyc[$];
   int raw_data[$];
   int done_cnt = 0;
   int s_cyc[$];

   always @(negedge clk) begin
      if (fb_we) begin
         wq_addr.push_back(int'(fb_addr));
         wq_data.push_back(int'(fb_wdata));
         wq_cyc.push_back(cyc);
         $display("wr cyc=%0d addr=%0d data=0x%02h", cyc, fb_addr, fb_wdata);
      end
      if (raw_we) raw_data.push_back(int'(raw_wdata));
      if (frame_done) begin
         done_cnt = done_cnt + 1;
         $display("frame_done cyc=%0d front_buf=%0b", cyc, front_buf);
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_mode(input logic [1:0] m, input int n);
      ppu_mode = m;
      repeat (n) tick();
   endtask

   task automatic push(input logic [1:0] p);
      px_in    = p;
      px_valid = 1'b1;
      s_cyc.push_back(cyc);
      tick();
      px_valid = 1'b0;
   endtask

   // kind 0: pixel pattern 0,1,2,3 repeating; kind 1: constant val
   task automatic run_line(input int n, input int kind, input logic [1:0] val);
      hold_mode(2'd2, 2);
      ppu_mode = 2'd3;
      tick();
      for (int i = 0; i < n; i++) push(kind == 0 ? 2'(i % 4) : val);
      hold_mode(2'd0, 3);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      px_valid = 1'b0;
      ppu_mode = 2'd1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic expect_wr(input string tag, input int idx, input int addr, input int data);
      if (idx < wq_addr.size()) begin
         check_eq({tag, "_addr"}, wq_addr[idx], addr);
         check_eq({tag, "_data"}, wq_data[idx], data);
      end else begin
         check_eq({tag, "_present"}, wq_addr.size(), idx + 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, b2, sb, rb, d;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_eq("rst_fb_we", fb_we, 0);
      check_eq("rst_fb_addr", fb_addr, 0);
      check_eq("rst_fb_wdata", fb_wdata, 0);
      check_eq("rst_front_buf", front_buf, 1);
      check_eq("rst_frame_done", frame_done, 0);
      check_eq("rst_frame_dropped", frame_dropped, 0);
      check_eq("rst_line_overrun", line_overrun, 0);

      // Full line, palette E4: 40 bytes of 1B at addresses 0..39, one cycle after each 4th strobe
      do_reset();
      palette = 8'hE4;
      b  = wq_addr.size();
      sb = s_cyc.size();
      hold_mode(2'd1, 3);
      run_line(160, 0, 2'd0);
      check_eq("line_wr_count", wq_addr.size() - b, 40);
      for (int k = 0; k < 40; k++) begin
         expect_wr("line_wr", b + k, k, 8'h1B);
         if (b + k < wq_cyc.size())
            check_eq("line_wr_latency", wq_cyc[b + k] - s_cyc[sb + 4 * k + 3], 1);
      end

      // Partial flush then palette 1B on the next line (raw instance passes index 0)
      do_reset();
      b = wq_addr.size();
      hold_mode(2'd1, 3);
      run_line(6, 1, 2'd3);
      palette = 8'h1B;
      rb = raw_data.size();
      run_line(4, 1, 2'd0);
      check_eq("partial_wr_count", wq_addr.size() - b, 3);
      expect_wr("partial_full", b, 0, 8'hFF);
      expect_wr("partial_flush", b + 1, 1, 8'hF0);
      expect_wr("palette_map", b + 2, 40, 8'hFF);
      check_eq("raw_wr_count", raw_data.size() - rb, 1);
      if (raw_data.size() > rb) check_eq("raw_data", raw_data[rb], 8'h00);
      palette = 8'hE4;

      // Full frame with idle display: swap, next frame goes to buffer 1
      do_reset();
      disp_busy = 1'b0;
      b = wq_addr.size();
      d = done_cnt;
      hold_mode(2'd1, 3);
      for (int l = 0; l < 144; l++) run_line(4, 0, 2'd0);
      check_eq("swap_wr_count", wq_addr.size() - b, 144);
      expect_wr("swap_last_line", b + 143, 5720, 8'h1B);
      check_eq("swap_done_pulses", done_cnt - d, 1);
      check_eq("swap_front_buf", front_buf, 0);
      check_eq("swap_dropped", frame_dropped, 0);
      b2 = wq_addr.size();
      hold_mode(2'd1, 3);
      run_line(4, 0, 2'd0);
      expect_wr("swap_next_frame", b2, 5760, 8'h1B);

      // Full frame with busy display: no swap, drop flagged, same buffer rewritten
      do_reset();
      disp_busy = 1'b1;
      d = done_cnt;
      hold_mode(2'd1, 3);
      for (int l = 0; l < 144; l++) run_line(4, 0, 2'd0);
      check_eq("busy_done_pulses", done_cnt - d, 1);
      check_eq("busy_front_buf", front_buf, 1);
      check_eq("busy_dropped", frame_dropped, 1);
      b2 = wq_addr.size();
      hold_mode(2'd1, 3);
      run_line(4, 0, 2'd0);
      expect_wr("busy_next_frame", b2, 0, 8'h1B);
      disp_busy = 1'b0;

      // Early VBLANK forces frame end
      do_reset();
      hold_mode(2'd1, 3);
      run_line(4, 0, 2'd0);
      d = done_cnt;
      hold_mode(2'd1, 4);
      check_eq("short_done_pulses", done_cnt - d, 1);
      check_eq("short_front_buf", front_buf, 0);

      // Overrun: 162 strobes in one line
      do_reset();
      check_eq("ovr_clear_after_rst", line_overrun, 0);
      b = wq_addr.size();
      hold_mode(2'd1, 3);
      run_line(162, 0, 2'd0);
      check_eq("ovr_wr_count", wq_addr.size() - b, 40);
      check_eq("ovr_flag", line_overrun, 1);

      // Reset mid-line after two pixels
      do_reset();
      hold_mode(2'd1, 3);
      hold_mode(2'd2, 2);
      ppu_mode = 2'd3;
      tick();
      push(2'd1);
      push(2'd2);
      b = wq_addr.size();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();
      check_eq("midrst_no_write", wq_addr.size() - b, 0);
      check_eq("midrst_fb_we", fb_we, 0);
      check_eq("midrst_fb_addr", fb_addr, 0);
      check_eq("midrst_fb_wdata", fb_wdata, 0);
      check_eq("midrst_front_buf", front_buf, 1);
      check_eq("midrst_overrun", line_overrun, 0);
      check_eq("midrst_dropped", frame_dropped, 0);

      // LCD off: pixels while waiting for a frame are ignored
      ppu_mode = 2'd1;
      b = wq_addr.size();
      for (int i = 0; i < 8; i++) push(2'(i % 4));
      hold_mode(2'd1, 3);
      check_eq("lcd_off_no_write", wq_addr.size() - b, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
